qeciphy_rx_checker: RTL and testbench

- Downstream consumer of the QECIPHY receive AXI-stream (RX_TDATA/RX_TVALID/RX_TREADY) in link bring-up and soak designs.
- Locks onto an incrementing 64-bit counter pattern sent by the far-end generator, then checks every received beat against it.
- Counts good beats and error beats; declares loss of lock after repeated mismatches and re-hunts automatically.
- Outputs feed LEDs, ILA probes and VIO readback.

---
 rtl/qeciphy_pkg.sv | 14 +
 rtl/qeciphy_sat_counter.sv | 22 ++
 rtl/qeciphy_rx_checker.sv | 150 +++++++++++++++
 tb/tb_qeciphy_rx_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qeciphy_pkg.sv
// Shared types and widths for the QECIPHY receive-side pattern checker.
package qeciphy_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned LOSS_CNT_W = 8;
  localparam int unsigned RUN_W      = 4;

  typedef enum logic [STATE_W-1:0] {
    CHK_IDLE   = 2'd0,
    CHK_HUNT   = 2'd1,
    CHK_LOCKED = 2'd2
  } chk_state_t;

endpackage

// File: rtl/qeciphy_sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module qeciphy_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         ACLK,
  input  logic         ARSTn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/qeciphy_rx_checker.sv
// Locks onto an incrementing counter pattern on the QECIPHY RX stream and
// counts good and bad beats, re-hunting after repeated mismatches.
module qeciphy_rx_checker
  import qeciphy_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned ERR_CNT_W  = 16,
  parameter int unsigned BEAT_CNT_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARSTn,
  input  logic                  en,
  input  logic                  clr_counts,
  input  logic [DATA_W-1:0]     RX_TDATA,
  input  logic                  RX_TVALID,
  output logic                  RX_TREADY,
  output logic                  locked,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [BEAT_CNT_W-1:0] beat_cnt,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [STATE_W-1:0]    state
);

  chk_state_t        state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [RUN_W-1:0]  miss_q, miss_d;
  logic              first_q, first_d;
  logic              err_inc, beat_inc, loss_inc, sticky_set;

  // State and pattern-tracking registers
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q    <= CHK_IDLE;
      exp_q      <= '0;
      run_q      <= '0;
      miss_q     <= '0;
      first_q    <= 1'b0;
      locked     <= 1'b0;
      err_sticky <= 1'b0;
      RX_TREADY  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      run_q      <= run_d;
      miss_q     <= miss_d;
      first_q    <= first_d;
      locked     <= (state_d == CHK_LOCKED);
      RX_TREADY  <= 1'b1;
      if (clr_counts) begin
        err_sticky <= 1'b0;
      end else if (sticky_set) begin
        err_sticky <= 1'b1;
      end
    end
  end

  // Next-state and counter-event decode
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    run_d      = run_q;
    miss_d     = miss_q;
    first_d    = first_q;
    err_inc    = 1'b0;
    beat_inc   = 1'b0;
    loss_inc   = 1'b0;
    sticky_set = 1'b0;

    if (!en) begin
      state_d = CHK_IDLE;
    end else begin
      unique case (state_q)
        CHK_IDLE: begin
          state_d = CHK_HUNT;
          first_d = 1'b1;
          run_d   = '0;
        end
        CHK_HUNT: begin
          if (RX_TVALID) begin
            // First beat or a break in the sequence reseeds from this beat
            if (first_q || (RX_TDATA != exp_q)) begin
              run_d = RUN_W'(1);
            end else begin
              run_d = run_q + RUN_W'(1);
            end
            exp_d   = RX_TDATA + DATA_W'(1);
            first_d = 1'b0;
            if (run_d >= RUN_W'(LOCK_COUNT)) begin
              state_d = CHK_LOCKED;
              miss_d  = '0;
            end
          end
        end
        CHK_LOCKED: begin
          if (RX_TVALID) begin
            exp_d = exp_q + DATA_W'(1);
            if (RX_TDATA == exp_q) begin
              beat_inc = 1'b1;
              miss_d   = '0;
            end else begin
              err_inc    = 1'b1;
              sticky_set = 1'b1;
              miss_d     = miss_q + RUN_W'(1);
            end
            if (miss_d >= RUN_W'(LOSS_COUNT)) begin
              state_d  = CHK_HUNT;
              loss_inc = 1'b1;
              first_d  = 1'b1;
              run_d    = '0;
            end
          end
        end
        default: begin
          state_d = CHK_IDLE;
        end
      endcase
    end
  end

  assign state = state_q;

  qeciphy_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .ACLK  (ACLK),
    .ARSTn (ARSTn),
    .inc   (err_inc),
    .clr   (clr_counts),
    .cnt   (err_cnt)
  );

  qeciphy_sat_counter #(.W(BEAT_CNT_W)) u_beat_cnt (
    .ACLK  (ACLK),
    .ARSTn (ARSTn),
    .inc   (beat_inc),
    .clr   (clr_counts),
    .cnt   (beat_cnt)
  );

  qeciphy_sat_counter #(.W(LOSS_CNT_W)) u_loss_cnt (
    .ACLK  (ACLK),
    .ARSTn (ARSTn),
    .inc   (loss_inc),
    .clr   (clr_counts),
    .cnt   (lock_loss_cnt)
  );

endmodule

// File: tb/tb_qeciphy_rx_checker.sv
// Bench for qeciphy_rx_checker: directed scenarios plus a randomized stream
// checked against a behavioural model of the lock/count rules.
module tb_qeciphy_rx_checker;

  logic        ACLK;
  logic        ARSTn;
  logic        en;
  logic        clr_counts;
  logic [63:0] RX_TDATA;
  logic        RX_TVALID;
  logic        RX_TREADY;
  logic        locked;
  logic        err_sticky;
  logic [15:0] err_cnt;
  logic [31:0] beat_cnt;
  logic [7:0]  lock_loss_cnt;
  logic [1:0]  state;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  int          m_state;
  logic [63:0] m_exp;
  int          m_run;
  int          m_miss;
  bit          m_first;
  int          m_err;
  longint      m_beat;
  int          m_loss;
  bit          m_sticky;
  bit          m_ready;

  logic [63:0] gen;

  qeciphy_rx_checker dut (
    .ACLK          (ACLK),
    .ARSTn         (ARSTn),
    .en            (en),
    .clr_counts    (clr_counts),
    .RX_TDATA      (RX_TDATA),
    .RX_TVALID     (RX_TVALID),
    .RX_TREADY     (RX_TREADY),
    .locked        (locked),
    .err_sticky    (err_sticky),
    .err_cnt       (err_cnt),
    .beat_cnt      (beat_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic model_reset();
    m_state = 0; m_exp = '0; m_run = 0; m_miss = 0; m_first = 0;
    m_err = 0; m_beat = 0; m_loss = 0; m_sticky = 0; m_ready = 0;
  endtask

  // One clock edge of the checker's rules, written directly from the behaviour
  task automatic model_edge(input bit e, input bit c, input bit v, input logic [63:0] d);
    int ns;
    bit good, bad, lost;
    ns = m_state; good = 0; bad = 0; lost = 0;
    m_ready = 1;
    if (!e) ns = 0;
    else if (m_state == 0) begin
      ns = 1; m_first = 1;
    end else if (m_state == 1 && v) begin
      m_run   = (!m_first && d == m_exp) ? m_run + 1 : 1;
      m_exp   = d + 64'd1;
      m_first = 0;
      if (m_run >= 4) begin ns = 2; m_miss = 0; end
    end else if (m_state == 2 && v) begin
      if (d == m_exp) begin good = 1; m_miss = 0; end
      else begin bad = 1; m_miss++; end
      m_exp = m_exp + 64'd1;
      if (m_miss >= 4) begin ns = 1; lost = 1; m_first = 1; end
    end
    m_state = ns;
    if (c) begin
      m_err = 0; m_beat = 0; m_loss = 0; m_sticky = 0;
    end else begin
      if (bad)  begin m_sticky = 1; if (m_err < 65535) m_err++; end
      if (good && m_beat < 64'(32'hFFFF_FFFF)) m_beat++;
      if (lost && m_loss < 255) m_loss++;
    end
  endtask

  task automatic step(input bit e, input bit c, input bit v, input logic [63:0] d);
    @(negedge ACLK);
    en = e; clr_counts = c; RX_TVALID = v; RX_TDATA = d;
    @(posedge ACLK);
    model_edge(e, c, v, d);
    #1;
  endtask

  task automatic test_reset();
    ARSTn = 1'b0; en = 0; clr_counts = 0; RX_TVALID = 0; RX_TDATA = '0;
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    n_total++; if (RX_TREADY !== 1'b0) $display("FAIL reset_tready got=%0b want=0", RX_TREADY); else n_pass++;
    n_total++; if ({locked, err_sticky, err_cnt, beat_cnt, lock_loss_cnt, state} !== '0)
      $display("FAIL reset_outputs got=%h want=0", {locked, err_sticky, err_cnt, beat_cnt, lock_loss_cnt, state});
    else n_pass++;
    @(negedge ACLK); ARSTn = 1'b1;
    step(0, 0, 0, '0);
    n_total++; if (RX_TREADY !== 1'b1) $display("FAIL tready_after_reset got=%0b want=1", RX_TREADY); else n_pass++;
    n_total++; if (state !== 2'd0) $display("FAIL idle_hold got=%0d want=0", state); else n_pass++;
  endtask

  task automatic test_lock();
    step(1, 0, 0, '0);
    n_total++; if (state !== 2'd1) $display("FAIL enter_hunt got=%0d want=1", state); else n_pass++;
    for (int i = 100; i <= 103; i++) begin
      step(1, 0, 1, 64'(i));
      if (i == 102) begin
        n_total++; if (locked !== 1'b0) $display("FAIL early_lock got=%0b want=0", locked); else n_pass++;
      end
    end
    n_total++; if (locked !== 1'b1 || state !== 2'd2)
      $display("FAIL lock_after_4 got=%0b/%0d want=1/2", locked, state);
    else n_pass++;
    n_total++; if (beat_cnt !== 32'd0) $display("FAIL hunt_no_count got=%0d want=0", beat_cnt); else n_pass++;
    for (int i = 104; i <= 203; i++) step(1, 0, 1, 64'(i));
    n_total++; if (beat_cnt !== 32'd100 || err_cnt !== 16'd0)
      $display("FAIL beat_100 got=%0d/%0d want=100/0", beat_cnt, err_cnt);
    else n_pass++;
    gen = 64'd204;
  endtask

  task automatic test_single_error();
    step(1, 0, 1, 64'hDEAD); gen++;
    n_total++; if (err_cnt !== 16'd1 || err_sticky !== 1'b1 || locked !== 1'b1)
      $display("FAIL single_err got=%0d/%0b/%0b want=1/1/1", err_cnt, err_sticky, locked);
    else n_pass++;
    step(1, 0, 1, gen); gen++;
    n_total++; if (beat_cnt !== 32'd101 || err_cnt !== 16'd1)
      $display("FAIL resume_good got=%0d/%0d want=101/1", beat_cnt, err_cnt);
    else n_pass++;
  endtask

  task automatic test_loss_relock();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, ~gen); gen++;
      if (i == 2) begin
        n_total++; if (locked !== 1'b1) $display("FAIL loss_early got=%0b want=1", locked); else n_pass++;
      end
    end
    n_total++; if (state !== 2'd1 || lock_loss_cnt !== 8'd1 || locked !== 1'b0)
      $display("FAIL loss got=%0d/%0d/%0b want=1/1/0", state, lock_loss_cnt, locked);
    else n_pass++;
    n_total++; if (err_cnt !== 16'd5) $display("FAIL loss_errs got=%0d want=5", err_cnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 64'h900 + 64'(i));
      if (i == 2) begin
        n_total++; if (state !== 2'd1) $display("FAIL relock_early got=%0d want=1", state); else n_pass++;
      end
    end
    n_total++; if (locked !== 1'b1 || beat_cnt !== 32'd101)
      $display("FAIL relock got=%0b/%0d want=1/101", locked, beat_cnt);
    else n_pass++;
    gen = 64'h904;
  endtask

  task automatic test_en_drop();
    step(0, 0, 1, gen);
    n_total++; if (state !== 2'd0 || locked !== 1'b0)
      $display("FAIL en_drop got=%0d/%0b want=0/0", state, locked);
    else n_pass++;
    n_total++; if (err_cnt !== 16'd5 || beat_cnt !== 32'd101 || lock_loss_cnt !== 8'd1 || err_sticky !== 1'b1)
      $display("FAIL en_drop_retain got=%0d/%0d/%0d/%0b want=5/101/1/1", err_cnt, beat_cnt, lock_loss_cnt, err_sticky);
    else n_pass++;
  endtask

  task automatic test_wrap_bubbles();
    step(1, 0, 0, '0);
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1, 0, 0, 64'h1234);
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1, 0, 0, 64'h0);
    step(1, 0, 0, 64'h55);
    step(1, 0, 1, 64'h0);
    step(1, 0, 0, 64'h7);
    step(1, 0, 1, 64'h1);
    n_total++; if (locked !== 1'b1 || err_cnt !== 16'd5)
      $display("FAIL wrap_lock got=%0b/%0d want=1/5", locked, err_cnt);
    else n_pass++;
    step(1, 0, 1, 64'h2);
    step(1, 0, 0, 64'h9);
    step(1, 0, 1, 64'h3);
    n_total++; if (beat_cnt !== 32'd103 || err_cnt !== 16'd5)
      $display("FAIL wrap_count got=%0d/%0d want=103/5", beat_cnt, err_cnt);
    else n_pass++;
    gen = 64'h4;
  endtask

  task automatic test_clr_same_cycle();
    step(1, 1, 1, 64'hBAD); gen++;
    n_total++; if (err_cnt !== 16'd0 || err_sticky !== 1'b0 || beat_cnt !== 32'd0 || lock_loss_cnt !== 8'd0)
      $display("FAIL clr_priority got=%0d/%0b/%0d/%0d want=0/0/0/0", err_cnt, err_sticky, beat_cnt, lock_loss_cnt);
    else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL clr_keeps_lock got=%0b want=1", locked); else n_pass++;
    step(1, 0, 1, gen); gen++;
    n_total++; if (beat_cnt !== 32'd1 || err_cnt !== 16'd0)
      $display("FAIL after_clr got=%0d/%0d want=1/0", beat_cnt, err_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int burst;
    logic [60:0] got, want;
    burst = 0;
    gen = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit e, c, v;
      logic [63:0] d;
      e = ($urandom_range(0, 99) != 0);
      c = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = gen;
      if (v) begin
        if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 6);
        if (burst > 0) begin
          d = {$urandom, $urandom};
          burst--;
        end
        gen++;
      end else begin
        d = {$urandom, $urandom};
      end
      step(e, c, v, d);
      got  = {RX_TREADY, locked, err_sticky, err_cnt, beat_cnt, lock_loss_cnt, state};
      want = {m_ready, (m_state == 2), m_sticky, 16'(m_err), 32'(m_beat), 8'(m_loss), 2'(m_state)};
      n_total++; if (got !== want) $display("FAIL random_cyc%0d got=%h want=%h", cyc, got, want); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin step(1, 0, 1, gen); gen++; end
    @(negedge ACLK);
    #2 ARSTn = 1'b0;
    #1;
    n_total++; if ({RX_TREADY, locked, err_sticky, err_cnt, beat_cnt, lock_loss_cnt, state} !== '0)
      $display("FAIL async_reset got=%h want=0", {RX_TREADY, locked, err_sticky, err_cnt, beat_cnt, lock_loss_cnt, state});
    else n_pass++;
    model_reset();
    @(posedge ACLK); #1;
    n_total++; if (state !== 2'd0 || RX_TREADY !== 1'b0)
      $display("FAIL reset_hold got=%0d/%0b want=0/0", state, RX_TREADY);
    else n_pass++;
    @(negedge ACLK); ARSTn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_en_drop();
    test_wrap_bubbles();
    test_clr_same_cycle();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
